maze_state: RTL and testbench

//  Owns the live maze tile map, pellet bookkeeping and score. It sits directly upstream of the
//  Pac-Man movement block. Each clk60 cycle it returns the 2-bit codes of the four tiles around
//  Pac-Man's current tile (tile_info), consumes the pellet on that tile, and reports score and

---
 rtl/maze_state.sv | 111 +++++++++++
 tb/tb_maze_state.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/maze_state.sv
// Live maze tile map, pellet bookkeeping and score; neighbour tile codes are 0-cycle combinational.
// Level image comes from ROM_IMAGE (row-major, 2 bits per tile) and is copied in one row per cycle.
module maze_state #(
    parameter int MAZE_W        = 28,
    parameter int MAZE_H        = 31,
    parameter int PELLET_POINTS = 10,
    parameter int SCORE_W       = 16,
    parameter logic [MAZE_H*MAZE_W*2-1:0] ROM_IMAGE = '0
) (
    input  logic               clk60,
    input  logic               reset,
    input  logic               level_restart,
    input  logic               eat_en,
    input  logic [6:0]         curr_xtile,
    input  logic [6:0]         curr_ytile,
    output logic [1:0]         tile_info [0:3],
    output logic               ready,
    output logic               pellet_eaten,
    output logic [7:0]         pellets_left,
    output logic [SCORE_W-1:0] score,
    output logic               level_clear
);
    localparam int XW = $clog2(MAZE_W);
    localparam int YW = $clog2(MAZE_H);
    localparam logic [1:0] WALL = 2'b00;
    localparam logic [1:0] WKNP = 2'b01;
    localparam logic [1:0] WKRP = 2'b10;

    typedef enum logic [1:0] {RESTORE, PLAY, CLEAR} state_t;

    state_t           state, state_nxt;
    logic [YW-1:0]    row;
    logic [1:0]       map [MAZE_H][MAZE_W];
    logic [XW-1:0]    x, x_r, x_l;
    logic [YW-1:0]    y;
    logic             on_maze, eat_now, last_row;
    logic [7:0]       row_pellets;
    logic [SCORE_W:0] score_sum;

    assign x         = curr_xtile[XW-1:0];
    assign y         = curr_ytile[YW-1:0];
    assign on_maze   = (curr_xtile < 7'(MAZE_W)) && (curr_ytile < 7'(MAZE_H));
    // Horizontal tunnel: the left and right edges are adjacent.
    assign x_r       = (x == XW'(MAZE_W-1)) ? '0 : x + 1'b1;
    assign x_l       = (x == '0) ? XW'(MAZE_W-1) : x - 1'b1;
    assign last_row  = (row == YW'(MAZE_H-1));
    assign eat_now   = (state == PLAY) && eat_en && on_maze && (map[y][x] == WKRP);
    assign score_sum = {1'b0, score} + (SCORE_W+1)'(PELLET_POINTS);

    always_comb begin
        row_pellets = '0;
        for (int i = 0; i < MAZE_W; i++)
            if (ROM_IMAGE[(int'(row)*MAZE_W + i)*2 +: 2] == WKRP)
                row_pellets = row_pellets + 8'd1;
    end

    always_ff @(posedge clk60) begin
        if (reset) state <= RESTORE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (level_restart) begin
            state_nxt = RESTORE;
        end else begin
            case (state)
                RESTORE: if (last_row)
                             state_nxt = ((pellets_left + row_pellets) == 8'd0) ? CLEAR : PLAY;
                PLAY:    if (eat_now && pellets_left == 8'd1) state_nxt = CLEAR;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        ready       = (state != RESTORE);
        level_clear = (state == CLEAR);
    end

    always_comb begin
        for (int d = 0; d < 4; d++) tile_info[d] = WALL;
        if (ready && on_maze) begin
            tile_info[0] = map[y][x_r];
            if (y != '0)              tile_info[1] = map[y - 1'b1][x];
            if (y != YW'(MAZE_H-1))   tile_info[2] = map[y + 1'b1][x];
            tile_info[3] = map[y][x_l];
        end
    end

    always_ff @(posedge clk60) begin
        if (reset || level_restart) begin
            row          <= '0;
            pellets_left <= '0;
            pellet_eaten <= 1'b0;
            if (reset) score <= '0;
        end else begin
            pellet_eaten <= eat_now;
            if (state == RESTORE) begin
                row          <= last_row ? '0 : row + 1'b1;
                pellets_left <= pellets_left + row_pellets;
                for (int i = 0; i < MAZE_W; i++)
                    map[row][i] <= ROM_IMAGE[(int'(row)*MAZE_W + i)*2 +: 2];
            end else if (eat_now) begin
                map[y][x] <= WKNP;
                if (pellets_left != 8'd0) pellets_left <= pellets_left - 8'd1;
                score <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_maze_state.sv
// Directed bench: three maze_state instances (244-pellet map, 2-pellet map, 2-pellet map with huge points).
module tb_maze_state;
    localparam int W = 28;
    localparam int H = 31;
    localparam int IMG_W = W*H*2;

    function automatic logic [IMG_W-1:0] std_image();
        logic [IMG_W-1:0] img;
        logic [1:0] c;
        img = '0;
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++) begin
                if (yy == 0 || yy == H-1)                     c = 2'd0;
                else if (xx == 0 || xx == W-1)                c = (yy == 14) ? ((xx == 0) ? 2'd3 : 2'd1) : 2'd0;
                else if (yy == 13 && xx >= 10 && xx <= 16)    c = 2'd3;
                else if (xx == 14 && yy == 23)                c = 2'd3;
                else if (xx == 13 && yy == 22)                c = 2'd0;
                else if (xx == 13 && yy == 24)                c = 2'd2;
                else if (yy % 4 == 1)                         c = 2'd2;
                else if (xx == 1 || xx == W-2)                c = 2'd2;
                else                                          c = 2'd1;
                img[(yy*W + xx)*2 +: 2] = c;
            end
        return img;
    endfunction

    function automatic logic [IMG_W-1:0] two_image();
        logic [IMG_W-1:0] img;
        img = '0;
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++)
                img[(yy*W + xx)*2 +: 2] = (yy == 2 && (xx == 2 || xx == 3)) ? 2'd2 : 2'd1;
        return img;
    endfunction

    localparam logic [IMG_W-1:0] STD_IMG = std_image();
    localparam logic [IMG_W-1:0] TWO_IMG = two_image();

    logic       clk60;
    logic       rst [3];
    logic       rl  [3];
    logic       eat [3];
    logic [6:0] xt  [3];
    logic [6:0] yt  [3];
    logic       rdy [3];
    logic       pe  [3];
    logic       lc  [3];
    logic [7:0] pl  [3];
    logic [15:0] sc [3];
    logic [1:0] ti0 [0:3];
    logic [1:0] ti1 [0:3];
    logic [1:0] ti2 [0:3];

    int checks = 0;
    int errors = 0;

    maze_state #(.ROM_IMAGE(STD_IMG)) dut0 (
        .clk60(clk60), .reset(rst[0]), .level_restart(rl[0]), .eat_en(eat[0]),
        .curr_xtile(xt[0]), .curr_ytile(yt[0]), .tile_info(ti0), .ready(rdy[0]),
        .pellet_eaten(pe[0]), .pellets_left(pl[0]), .score(sc[0]), .level_clear(lc[0]));

    maze_state #(.ROM_IMAGE(TWO_IMG)) dut1 (
        .clk60(clk60), .reset(rst[1]), .level_restart(rl[1]), .eat_en(eat[1]),
        .curr_xtile(xt[1]), .curr_ytile(yt[1]), .tile_info(ti1), .ready(rdy[1]),
        .pellet_eaten(pe[1]), .pellets_left(pl[1]), .score(sc[1]), .level_clear(lc[1]));

    maze_state #(.ROM_IMAGE(TWO_IMG), .PELLET_POINTS(65530)) dut2 (
        .clk60(clk60), .reset(rst[2]), .level_restart(rl[2]), .eat_en(eat[2]),
        .curr_xtile(xt[2]), .curr_ytile(yt[2]), .tile_info(ti2), .ready(rdy[2]),
        .pellet_eaten(pe[2]), .pellets_left(pl[2]), .score(sc[2]), .level_clear(lc[2]));

    initial clk60 = 1'b0;
    always #5 clk60 = ~clk60;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk60);
        #1;
    endtask

    task automatic wait_ready(input int i, output int n);
        n = 0;
        while (!rdy[i] && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic place(input int i, input int px, input int py, input logic e);
        xt[i]  = 7'(px);
        yt[i]  = 7'(py);
        eat[i] = e;
        #1;
    endtask

    int n;
    int pulses;

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; rl[i] = 1'b0; eat[i] = 1'b0; xt[i] = 7'd13; yt[i] = 7'd23;
        end
        tick();
        chk("reset_ready", 32'(rdy[0]), 0);
        chk("reset_score", 32'(sc[0]), 0);
        chk("reset_pellets", 32'(pl[0]), 0);
        chk("reset_clear", 32'(lc[0]), 0);
        chk("reset_tiles_wall", 32'({ti0[0], ti0[1], ti0[2], ti0[3]}), 0);
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        wait_ready(0, n);
        chk("reload_cycles", 32'(n), 31);
        chk("std_pellets", 32'(pl[0]), 244);
        chk("std_score", 32'(sc[0]), 0);
        chk("two_pellets", 32'(pl[1]), 2);

        // neighbour lookup, tunnel wrap, vertical edges
        place(0, 13, 23, 1'b0);
        chk("nb_right", 32'(ti0[0]), 3);
        chk("nb_up", 32'(ti0[1]), 0);
        chk("nb_down", 32'(ti0[2]), 2);
        chk("nb_left", 32'(ti0[3]), 1);
        place(0, 27, 14, 1'b0);
        chk("wrap_right", 32'(ti0[0]), 3);
        chk("wrap_right_left", 32'(ti0[3]), 2);
        place(0, 0, 14, 1'b0);
        chk("wrap_left", 32'(ti0[3]), 1);
        chk("wrap_left_right", 32'(ti0[0]), 2);
        place(0, 5, 0, 1'b0);
        chk("top_up_wall", 32'(ti0[1]), 0);
        chk("top_down", 32'(ti0[2]), 2);
        place(0, 5, 30, 1'b0);
        chk("bot_down_wall", 32'(ti0[2]), 0);
        chk("bot_up", 32'(ti0[1]), 2);

        // sit on a pellet for 5 cycles
        place(0, 13, 24, 1'b1);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            pulses += int'(pe[0]);
        end
        chk("eat_pulses", 32'(pulses), 1);
        chk("eat_score", 32'(sc[0]), 10);
        chk("eat_pellets", 32'(pl[0]), 243);
        place(0, 13, 23, 1'b0);
        chk("eaten_tile_wknp", 32'(ti0[2]), 1);
        place(0, 5, 5, 1'b0);
        tick(); tick();
        chk("no_eat_en_pellets", 32'(pl[0]), 243);
        chk("no_eat_en_score", 32'(sc[0]), 10);

        // off-maze current tile
        place(0, 5, 125, 1'b1);
        chk("offmaze_y_wall", 32'({ti0[0], ti0[1], ti0[2], ti0[3]}), 0);
        tick(); tick();
        chk("offmaze_no_eat", 32'(pl[0]), 243);
        place(0, 28, 14, 1'b1);
        chk("offmaze_x_wall", 32'({ti0[0], ti0[1], ti0[2], ti0[3]}), 0);
        eat[0] = 1'b0;

        // two-pellet level to CLEAR
        place(1, 2, 2, 1'b1);
        tick();
        chk("two_first_pulse", 32'(pe[1]), 1);
        chk("two_first_left", 32'(pl[1]), 1);
        chk("two_first_clear", 32'(lc[1]), 0);
        place(1, 3, 2, 1'b1);
        tick();
        chk("two_clear", 32'(lc[1]), 1);
        chk("two_clear_score", 32'(sc[1]), 20);
        chk("two_clear_left", 32'(pl[1]), 0);
        tick(); tick();
        chk("clear_no_pulse", 32'(pe[1]), 0);
        chk("clear_score_held", 32'(sc[1]), 20);
        eat[1] = 1'b0;
        rl[1] = 1'b1;
        tick();
        rl[1] = 1'b0;
        chk("restart_not_ready", 32'(rdy[1]), 0);
        wait_ready(1, n);
        chk("restart_cycles", 32'(n), 31);
        chk("restart_score_kept", 32'(sc[1]), 20);
        chk("restart_clear_low", 32'(lc[1]), 0);
        chk("restart_pellets", 32'(pl[1]), 2);
        rst[1] = 1'b1; rl[1] = 1'b1;
        tick();
        rst[1] = 1'b0; rl[1] = 1'b0;
        chk("reset_and_restart_score", 32'(sc[1]), 0);

        // reset in the middle of a reload
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        chk("midscan_not_ready", 32'(rdy[0]), 0);
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        wait_ready(0, n);
        chk("midscan_reload_cycles", 32'(n), 31);
        chk("midscan_score", 32'(sc[0]), 0);
        chk("midscan_pellets", 32'(pl[0]), 244);

        // score saturation
        place(2, 2, 2, 1'b1);
        tick();
        chk("sat_first", 32'(sc[2]), 65530);
        place(2, 3, 2, 1'b1);
        tick();
        chk("sat_second", 32'(sc[2]), 65535);
        eat[2] = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
